alu_core: RTL
=============

# alu_core

Sequential 18-bit arithmetic unit sitting directly downstream of the ALU operand multiplexers. It consumes `alu_a` (from ALU mux A) and `alu_b` (from ALU mux B) under an opcode from the control unit. It executes single-cycle add/sub/inc/dec/pass operations and an iterative shift-add multiply. Results go to a registered output bus with a zero flag that the control unit uses for loop and bound tests (row/column/index counters).

## Interface
Parameters:
- `WIDTH`, 18, datapath width; also the number of multiply iterations.

Ports:
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `alu_a` in WIDTH: operand A from ALU mux A.
- `alu_b` in WIDTH: operand B from ALU mux B.
- `alu_op` in 3: opcode, sampled only with `start`.
- `start` in 1: request; accepted only when `busy`=0.
- `busy` out 1: high while a multiply is in progress.
- `done` out 1: one-cycle pulse; `alu_out`/flags updated in the same cycle.
- `alu_out` out WIDTH: registered result, held until next `done`.
- `z_flag` out 1: registered; 1 when the last result was all zeros.
- `c_flag` out 1: carry/borrow/overflow (see Configuration).

## Operation
- Opcodes: 000 PASS_A; 001 ADD (A+B); 010 SUB (A−B); 011 MUL (A×B); 100 INC_A (A+1); 101 DEC_A (A−1); 110 PASS_B; 111 CLR (result 0).
- All arithmetic is unsigned modulo 2^WIDTH. The result is the low WIDTH bits.
- FSM states: IDLE, MUL.
  - IDLE + `start` + non-MUL op: result written at that edge, `done`=1 next cycle, stay IDLE.
  - IDLE + `start` + MUL: latch A (multiplicand), B (multiplier), clear accumulator, counter=0, go to MUL.
  - MUL: each edge examines multiplier LSB, conditionally adds the shifted multiplicand into the accumulator, shifts, and increments the counter.
  - After WIDTH iterations: write `alu_out`, pulse `done`, return to IDLE.
- `start` while `busy`=1 is ignored. It is neither queued nor does it affect the operation in progress.
- Operand inputs may change freely during MUL; only the latched copies are used.
- `z_flag` and `c_flag` update only on edges that raise `done`.

## Timing
- Reset values: `alu_out`=0, `z_flag`=0, `c_flag`=0, `done`=0, `busy`=0; state IDLE, counter 0.
- Non-MUL latency: `start` sampled at edge k → `done`=1 and result valid in the cycle after edge k.
- Back-to-back `start` every cycle is legal for non-MUL ops. In that case `done` stays high continuously.
- MUL latency: `start` at edge k → `busy`=1 from after edge k through edge k+WIDTH. `done`=1 and result valid after edge k+WIDTH (18 cycles). `busy`=0 in that same cycle.
- A new `start` is accepted in the `done` cycle of a MUL, giving zero dead cycles.
- `rst` during MUL aborts immediately: no `done`, outputs return to reset values.
- `rst` and `start` in the same cycle: `rst` wins.

## Configuration
- `ALU_CARRY_EN` defined:
  - `c_flag` = ADD/INC carry-out, SUB/DEC borrow, or MUL nonzero upper WIDTH bits of the full 2·WIDTH product. The accumulator is 2·WIDTH bits wide.
  - `c_flag`=0 for PASS_A/PASS_B/CLR.
- `ALU_CARRY_EN` undefined:
  - `c_flag` tied to 0.
  - Accumulator is WIDTH bits only; `alu_out` results are identical to the defined case.

## Test plan
- ADD A=5, B=7 → `done` one cycle after `start`, `alu_out`=12, `z_flag`=0, `c_flag`=0.
- SUB A=3, B=5 → `alu_out`=0x3FFFE, `c_flag`=1 (macro on) / 0 (off). Then SUB 9−9 → `alu_out`=0, `z_flag`=1.
- MUL A=1000, B=1000 → `busy` high 18 cycles, `done` at cycle 18, `alu_out`=213568 (1,000,000 mod 2^18), `c_flag`=1 with macro. MUL 300×400 → 120000, `c_flag`=0.
- During MUL 300×400, pulse `start` with ADD and change `alu_a`/`alu_b` at cycle 5 → ignored; result still 120000 at cycle 18, exactly one `done`.
- Assert `rst` at cycle 10 of a MUL → no `done`; `alu_out`=0, `busy`=0. A following INC_A A=0x3FFFF → `alu_out`=0, `z_flag`=1, `c_flag`=1 (macro on).
- MUL completes, then ADD `start` in its `done` cycle → ADD result one cycle later; CLR → `alu_out`=0, `z_flag`=1.

Source files
------------

// File: rtl/alu_core.sv
// 18-bit sequential ALU: single-cycle add/sub/inc/dec/pass/clr plus an iterative shift-add multiply.
// Optional ALU_CARRY_EN: widens the multiply accumulator and drives c_flag with carry/borrow/overflow.
module alu_core #(
    parameter int unsigned WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [2:0]       alu_op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_out,
    output logic             z_flag,
    output logic             c_flag
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
`ifdef ALU_CARRY_EN
    localparam int unsigned AW = 2 * WIDTH;
`else
    localparam int unsigned AW = WIDTH;
`endif

    localparam logic [2:0] OP_PASS_A = 3'b000;
    localparam logic [2:0] OP_ADD    = 3'b001;
    localparam logic [2:0] OP_SUB    = 3'b010;
    localparam logic [2:0] OP_MUL    = 3'b011;
    localparam logic [2:0] OP_INC    = 3'b100;
    localparam logic [2:0] OP_DEC    = 3'b101;
    localparam logic [2:0] OP_PASS_B = 3'b110;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [AW-1:0]    mcand;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    acc_step;
    logic [WIDTH-1:0] mplier;
    logic             accept;
    logic             last_iter;
    logic             done_nxt;
    logic             busy_nxt;
    logic             c_nxt;
    logic [WIDTH-1:0] out_nxt;
    logic [WIDTH:0]   ext;

    assign accept    = (state == S_IDLE) && start;
    assign last_iter = (state == S_MUL) && (cnt == CW'(WIDTH - 1));
    assign acc_step  = mplier[0] ? (acc + mcand) : acc;

`ifndef ALU_CARRY_EN
    logic unused_carry;
    assign unused_carry = ext[WIDTH];
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start && (alu_op == OP_MUL)) begin
                    state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; ext carries one extra bit for carry/borrow
    always_comb begin
        ext      = '0;
        out_nxt  = '0;
        c_nxt    = 1'b0;
        done_nxt = 1'b0;
        busy_nxt = (state_nxt == S_MUL);
        if (accept && (alu_op != OP_MUL)) begin
            done_nxt = 1'b1;
            case (alu_op)
                OP_PASS_A: ext = {1'b0, alu_a};
                OP_ADD:    ext = {1'b0, alu_a} + {1'b0, alu_b};
                OP_SUB:    ext = {1'b0, alu_a} - {1'b0, alu_b};
                OP_INC:    ext = {1'b0, alu_a} + (WIDTH + 1)'(1);
                OP_DEC:    ext = {1'b0, alu_a} - (WIDTH + 1)'(1);
                OP_PASS_B: ext = {1'b0, alu_b};
                default:   ext = '0;
            endcase
            out_nxt = ext[WIDTH-1:0];
`ifdef ALU_CARRY_EN
            c_nxt = ext[WIDTH];
`endif
        end else if (last_iter) begin
            done_nxt = 1'b1;
            out_nxt  = acc_step[WIDTH-1:0];
`ifdef ALU_CARRY_EN
            c_nxt = |acc_step[AW-1:WIDTH];
`endif
        end
    end

    // Output registers and multiply datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            done    <= 1'b0;
            busy    <= 1'b0;
            alu_out <= '0;
            z_flag  <= 1'b0;
            c_flag  <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            done <= done_nxt;
            busy <= busy_nxt;
            if (done_nxt) begin
                alu_out <= out_nxt;
                z_flag  <= (out_nxt == '0);
                c_flag  <= c_nxt;
            end
            if (accept && (alu_op == OP_MUL)) begin
                mcand  <= AW'(alu_a);
                mplier <= alu_b;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == S_MUL) begin
                acc    <= acc_step;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
            end
        end
    end

endmodule
